// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one shared 4-bit CLA slice is stepped over
// the operands one nibble per cycle, LSB first, with valid/ready on both sides.

module fourBitCLA (
  input  logic [3:0] InA,
  input  logic [3:0] InB,
  input  logic       c0,
  output logic [3:0] Out,
  output logic       c4
);
  logic [3:0] p, g, c;
  logic       gg, gp;

  assign p = InA ^ InB;
  assign g = InA & InB;

  // Flat lookahead: every carry derived directly from c0
  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;
  assign c4   = gg | (gp & c0);
  assign Out  = p ^ c;
endmodule

module cla_nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ofl,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NIB-1:0][3:0]    a_r, b_r, sum_q, sum_nxt;
  logic [IW-1:0]          idx;
  logic                   carry;
  logic [3:0]             s_out;
  logic                   s_c4;
  logic                   last;

  fourBitCLA u_slice (
    .InA (a_r[idx]),
    .InB (b_r[idx]),
    .c0  (carry),
    .Out (s_out),
    .c4  (s_c4)
  );

  assign last      = (idx == IW'(NIB - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Running sum with the current nibble merged in, so zero covers the final slice
  always_comb begin
    sum_nxt      = sum_q;
    sum_nxt[idx] = s_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_q <= '0;
      idx   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ofl   <= 1'b0;
      zero  <= 1'b0;
    end else if (flush) begin
      sum_q <= '0;
      idx   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ofl   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          carry <= sub;
          idx   <= '0;
          sum_q <= '0;
        end
        RUN: begin
          sum_q[idx] <= s_out;
          carry      <= s_c4;
          if (last) begin
            idx  <= '0;
            cout <= s_c4;
            ofl  <= (a_r[NIB-1][3] == b_r[NIB-1][3]) & (s_out[3] != a_r[NIB-1][3]);
            zero <= (sum_nxt == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Scoreboard bench: directed 16-bit vectors, a 4-bit instance and a 32-bit
// random run against an arithmetic reference.

module tb_cla_nibble_seq_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  logic rst, flush;

  // 16-bit instance
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ofl, zero;
  logic [15:0] a, b, sum;
  // 4-bit instance
  logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ofl4, zero4;
  logic [3:0]  a4, b4, sum4;
  // 32-bit instance
  logic        in_valid32, in_ready32, sub32, out_valid32, out_ready32, cout32, ofl32, zero32;
  logic [31:0] a32, b32, sum32;

  cla_nibble_seq_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ofl(ofl), .zero(zero));

  cla_nibble_seq_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .sub(sub4), .flush(1'b0), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ofl(ofl4), .zero(zero4));

  cla_nibble_seq_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .sub(sub32), .flush(1'b0), .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ofl(ofl32), .zero(zero32));

  typedef struct {
    logic [31:0] s;
    logic        c, o, z;
    int          acc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitors: check each result on the cycle out_valid rises, then hold stability
  logic        pv16 = 1'b0, pv32 = 1'b0;
  logic [15:0] held16;
  logic [31:0] held32;
  exp_t        e16, e32;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("in_ready_in_done16", in_ready, 0);
      if (!pv16) begin
        if (q16.size() == 0) fail("unexpected_out16");
        else begin
          e16 = q16.pop_front();
          chk("sum16",  sum,  e16.s[15:0]);
          chk("cout16", cout, e16.c);
          chk("ofl16",  ofl,  e16.o);
          chk("zero16", zero, e16.z);
          chk("lat16",  cyc - e16.acc, 4);
        end
        held16 = sum;
      end else chk("hold16", sum, held16);
    end
    pv16 = out_valid & !rst;
  end

  always @(negedge clk) begin
    if (!rst && out_valid32) begin
      if (!pv32) begin
        if (q32.size() == 0) fail("unexpected_out32");
        else begin
          e32 = q32.pop_front();
          chk("sum32",  sum32,  e32.s);
          chk("cout32", cout32, e32.c);
          chk("ofl32",  ofl32,  e32.o);
          chk("zero32", zero32, e32.z);
          chk("lat32",  cyc - e32.acc, 8);
        end
        held32 = sum32;
      end else chk("hold32", sum32, held32);
    end
    pv32 = out_valid32 & !rst;
  end

  bit run32 = 0;
  always @(negedge clk) if (run32) out_ready32 = 1'($urandom_range(0, 1));

  // Called on a negedge; returns on the negedge after the accept edge
  task automatic issue16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         input bit push, input logic [15:0] es, input logic ec,
                         input logic eo, input logic ez);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) fail("issue16_timeout");
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    if (push) q16.push_back('{{16'h0, es}, ec, eo, ez, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain16();
    int n = 0;
    while ((q16.size() != 0 || !in_ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail("drain16_timeout");
  endtask

  task automatic issue32(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    int n = 0;
    logic [32:0] t;
    logic [31:0] bb;
    while (!in_ready32 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready32) fail("issue32_timeout");
    bb = ts ? ~tb : tb;
    t  = {1'b0, ta} + {1'b0, bb} + {32'h0, ts};
    a32 = ta; b32 = tb; sub32 = ts; in_valid32 = 1'b1;
    q32.push_back('{t[31:0], t[32], (ta[31] == bb[31]) && (t[31] != ta[31]),
                    t[31:0] == 32'h0, cyc + 1});
    @(negedge clk);
    in_valid32 = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 0; a = '0; b = '0; sub = 0; out_ready = 1;
    in_valid4 = 0; a4 = '0; b4 = '0; sub4 = 0; out_ready4 = 1;
    in_valid32 = 0; a32 = '0; b32 = '0; sub32 = 0; out_ready32 = 1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum",       sum, 0);
    chk("rst_flags",     {cout, ofl, zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic vectors
    issue16(16'h1234, 16'h0FCD, 0, 1, 16'h2201, 0, 0, 0); drain16();
    issue16(16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1, 0); drain16();
    issue16(16'hFFFF, 16'h0001, 0, 1, 16'h0000, 1, 0, 1); drain16();
    issue16(16'h0005, 16'h0005, 1, 1, 16'h0000, 1, 0, 1); drain16();
    issue16(16'h0003, 16'h0005, 1, 1, 16'hFFFE, 0, 0, 0); drain16();

    // Backpressure in DONE with a stray in_valid pulse
    out_ready = 0;
    issue16(16'h7FFF, 16'h0001, 0, 1, 16'h8000, 0, 1, 0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    if (!out_valid) fail("bp_no_valid");
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 2); a = 16'h1111; b = 16'h2222; sub = 0;
      @(negedge clk);
    end
    in_valid = 0;
    chk("bp_valid_held", out_valid, 1);
    out_ready = 1;
    @(negedge clk);
    chk("bp_out_valid_drop", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    repeat (8) @(negedge clk);

    // Async reset during the second RUN cycle
    issue16(16'h1234, 16'h1111, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    chk("arst_flags", {cout, ofl, zero}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(negedge clk);

    // Flush in RUN, then a fresh op
    issue16(16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sum", sum, 0);
    repeat (8) @(negedge clk);
    // flush wins over in_valid in IDLE
    a = 16'h4444; b = 16'h1111; sub = 0; in_valid = 1; flush = 1;
    @(negedge clk);
    in_valid = 0; flush = 0;
    chk("flush_vs_accept", in_ready, 1);
    repeat (8) @(negedge clk);
    issue16(16'h0001, 16'h0001, 0, 1, 16'h0002, 0, 0, 0); drain16();

    // WIDTH=4: single RUN cycle
    a4 = 4'h7; b4 = 4'h1; sub4 = 0; in_valid4 = 1;
    @(negedge clk);
    in_valid4 = 0;
    chk("w4_run_not_done", out_valid4, 0);
    @(negedge clk);
    chk("w4_valid", out_valid4, 1);
    chk("w4_sum", sum4, 4'h8);
    chk("w4_ofl", ofl4, 1);
    chk("w4_cout_zero", {cout4, zero4}, 0);
    @(negedge clk);
    chk("w4_idle", in_ready4, 1);

    // WIDTH=32 random ops with random out_ready
    run32 = 1;
    for (int i = 0; i < 1000; i++)
      issue32($urandom, (i % 7 == 0) ? 32'h0 : $urandom, 1'($urandom_range(0, 1)));
    run32 = 0;
    @(negedge clk);
    out_ready32 = 1;
    for (int n = 0; n < 200 && (q32.size() != 0 || !in_ready32); n++) @(negedge clk);
    if (q32.size() != 0) fail("drain32_timeout");
    if (q16.size() != 0) fail("q16_leftover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
